rf_stage: RTL and testbench
===========================

// Module: rf_stage
// PURPOSE
//  Register-fetch/decode stage of the 5-stage Beta pipeline (IF->RF->ALU->MEM->WB). Consumes id_RF/pc_RF
//  from fetch, owns the 32x32 register file, bypasses ALU/MEM/WB results, detects load-use hazards,
//  resolves BEQ/BNE/JMP, flags illegal opcodes. Drives redirect/stall back to fetch; registers operands to ALU.
// PARAMETERS
//  NOP_INSTR  32'h83fff800  bubble injected into ALU stage (ADD R31,R31,R31)
//  XP_BNE     32'h77df0000  BNE(R31,0,XP) substituted for an illegal opcode (links PC into R30)
// PORTS
//  clk        in   1   clock
//  n_rst      in   1   reset, asynchronous, active-low
//  id_RF      in   32  instruction from fetch
//  pc_RF      in   32  PC+4 of id_RF (bit31 = supervisor)
//  alu_we     in   1   ALU-stage instr writes alu_rc      | alu_ld in 1  ALU-stage instr is LD/LDR
//  alu_rc     in   5   ALU-stage dest reg                 | alu_val in 32 ALU-stage result
//  mem_we     in   1   MEM-stage writes mem_rc            | mem_ld in 1  MEM-stage is LD/LDR
//  mem_rc     in   5   MEM-stage dest reg                 | mem_val in 32 MEM-stage result
//  wb_we      in   1   WB write enable                    | wb_rc in 5   WB dest reg
//  wb_val     in   32  WB write data (also bypass source)
//  stall      out  1   hold fetch + RF; inject bubble into ALU
//  bt         out  1   branch taken                       | jt out 1     JMP taken
//  pc_offset  out  32  branch target pc_RF + 4*sext(lit)  | rd1 out 32   bypassed Ra value (JMP target)
//  RF_exp     out  1   illegal opcode in RF
//  id_ALU     out  32  registered instruction to ALU      | pc_ALU out 32 registered pc_RF
//  a_ALU      out  32  registered operand A               | b_ALU out 32 registered operand B
//  d_ALU      out  32  registered store data (Rc value for ST)
// BEHAVIOUR
//  Decode: op=id[31:26], rc=[25:21], ra=[20:16], rb=[15:11], lit=sext(id[15:0]).
//  Legal: LD 18,ST 19,JMP 1B,BEQ 1C,BNE 1D,LDR 1F, OP 20-26,28-2E, OPC 30-36,38-3E (hex). All else illegal.
//  Read ports: port1=ra; port2=rc if ST, else rb. R31 always reads 0 and is never bypassed.
//  Bypass priority per port, for nonzero matching reg: ALU > MEM > WB > regfile. Combinational.
//  Regfile: write wb_val to wb_rc on posedge when wb_we && wb_rc!=31; same-cycle read sees it via WB bypass.
//  stall = a used source (port1 always; port2 for OP/ST) matches alu_rc with alu_we&&alu_ld, or mem_rc
//   with mem_we&&mem_ld (rc!=31). Combinational from inputs; no internal state.
//  bt = BEQ&&rd1==0 or BNE&&rd1!=0; jt = JMP; RF_exp = illegal. All three forced 0 while stall=1.
//  rd1 = bypassed port1 value; pc_offset = pc_RF + (lit<<2), 32-bit wrap, bit31 ignored by fetch.
//  ALU pipeline regs, posedge clk:
//   stall: id_ALU<=NOP_INSTR, pc_ALU<=pc_RF, a/b/d<=0 (RF inputs held upstream, re-evaluated next cycle).
//   RF_exp: id_ALU<=XP_BNE, pc_ALU<=pc_RF, a_ALU<=pc_RF, b/d<=0.
//   OP: a=port1, b=port2. OPC/LD: a=port1, b=lit. ST: a=port1, b=lit, d=port2.
//   LDR: a=pc_offset, b=0. BEQ/BNE/JMP: a=pc_RF (link value), b=0. id_ALU<=id_RF, pc_ALU<=pc_RF.
//  Reset (async): id_ALU=NOP_INSTR, pc_ALU=a/b/d=0, all 31 regs=0. Comb outputs then follow id_RF.
//  Reset mid-stall: pipeline regs go to reset values immediately; no pending state retained.
//  Annulled slot: fetch supplies NOP after bt/jt/RF_exp; RF treats it as an ordinary ADD to R31.
// TESTING
//  1 Reset: n_rst=0 mid-run -> id_ALU=83fff800, a/b/d=0, regfile R1 reads 0 after release.
//  2 Bypass: WB R1=5, MEM R1=7, ALU R1=9 same cycle; ADD(R1,R1,R2) -> a_ALU=9; drop ALU -> 7; drop MEM -> 5.
//  3 Load-use: LD into R3 in ALU, OP reads R3 -> stall=1 one cycle, bubble 83fff800; next cycle mem_ld path stalls again, then a_ALU=WB value.
//  4 Branch: BEQ(R31,lit=-2) with pc_RF=0x100 -> bt=1, pc_offset=0xF8; BNE same -> bt=0; branch during stall -> bt=0.
//  5 JMP: R4=0x8000_0040 -> jt=1, rd1=0x8000_0040, a_ALU=pc_RF.
//  6 Illegal op 0x00 -> RF_exp=1, id_ALU=77df0000, a_ALU=pc_RF; ST(R5,lit,R6) -> d_ALU=R5 value, b_ALU=sext lit.

Source files
------------

// File: rtl/rf_stage.sv
// Register-fetch stage of the 5-stage Beta pipeline: register file, operand bypass,
// load-use stall, branch/JMP resolution, illegal-opcode trap and the ALU pipeline registers.
module rf_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h83ff_f800,
    parameter logic [31:0] XP_BNE    = 32'h77df_0000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] id_RF,
    input  logic [31:0] pc_RF,
    input  logic        alu_we,
    input  logic        alu_ld,
    input  logic [4:0]  alu_rc,
    input  logic [31:0] alu_val,
    input  logic        mem_we,
    input  logic        mem_ld,
    input  logic [4:0]  mem_rc,
    input  logic [31:0] mem_val,
    input  logic        wb_we,
    input  logic [4:0]  wb_rc,
    input  logic [31:0] wb_val,
    output logic        stall,
    output logic        bt,
    output logic        jt,
    output logic [31:0] pc_offset,
    output logic [31:0] rd1,
    output logic        RF_exp,
    output logic [31:0] id_ALU,
    output logic [31:0] pc_ALU,
    output logic [31:0] a_ALU,
    output logic [31:0] b_ALU,
    output logic [31:0] d_ALU
);

    logic [5:0]  op_s;
    logic [4:0]  rc_s, ra_s, rb_s, r2_s;
    logic [31:0] lit_s;
    logic        is_ld_s, is_st_s, is_jmp_s, is_beq_s, is_bne_s, is_ldr_s;
    logic        is_op_s, is_opc_s, is_ill_s;
    logic [31:0] regs_r [0:31];
    logic [31:0] port1_s, port2_s, pc_offset_s;
    logic        haz1_s, haz2_s, stall_s;

    // Most recent producer wins; R31 is hard-wired zero and never forwarded.
    function automatic logic [31:0] bypass(
        input logic [4:0]  r,
        input logic [31:0] rf_val,
        input logic        a_we, input logic [4:0] a_rc, input logic [31:0] a_val,
        input logic        m_we, input logic [4:0] m_rc, input logic [31:0] m_val,
        input logic        w_we, input logic [4:0] w_rc, input logic [31:0] w_val
    );
        logic [31:0] v;
        if (r == 5'd31)                 v = 32'd0;
        else if (a_we && a_rc == r)     v = a_val;
        else if (m_we && m_rc == r)     v = m_val;
        else if (w_we && w_rc == r)     v = w_val;
        else                            v = rf_val;
        return v;
    endfunction

    function automatic logic load_hit(
        input logic [4:0] r,
        input logic a_we, input logic a_ld, input logic [4:0] a_rc,
        input logic m_we, input logic m_ld, input logic [4:0] m_rc
    );
        return (r != 5'd31) &&
               ((a_we && a_ld && a_rc == r) || (m_we && m_ld && m_rc == r));
    endfunction

    assign op_s  = id_RF[31:26];
    assign rc_s  = id_RF[25:21];
    assign ra_s  = id_RF[20:16];
    assign rb_s  = id_RF[15:11];
    assign lit_s = {{16{id_RF[15]}}, id_RF[15:0]};

    // Opcode decode; OP/OPC groups are 0x20/0x30 rows minus the xx7 columns.
    always_comb begin
        is_ld_s  = 1'b0;
        is_st_s  = 1'b0;
        is_jmp_s = 1'b0;
        is_beq_s = 1'b0;
        is_bne_s = 1'b0;
        is_ldr_s = 1'b0;
        is_op_s  = 1'b0;
        is_opc_s = 1'b0;
        is_ill_s = 1'b0;
        case (op_s)
            6'h18:   is_ld_s  = 1'b1;
            6'h19:   is_st_s  = 1'b1;
            6'h1B:   is_jmp_s = 1'b1;
            6'h1C:   is_beq_s = 1'b1;
            6'h1D:   is_bne_s = 1'b1;
            6'h1F:   is_ldr_s = 1'b1;
            default: begin
                if (op_s[5:4] == 2'b10 && op_s[2:0] != 3'b111)
                    is_op_s = 1'b1;
                else if (op_s[5:4] == 2'b11 && op_s[2:0] != 3'b111)
                    is_opc_s = 1'b1;
                else
                    is_ill_s = 1'b1;
            end
        endcase
    end

    assign r2_s    = is_st_s ? rc_s : rb_s;
    assign port1_s = bypass(ra_s, regs_r[ra_s], alu_we, alu_rc, alu_val,
                            mem_we, mem_rc, mem_val, wb_we, wb_rc, wb_val);
    assign port2_s = bypass(r2_s, regs_r[r2_s], alu_we, alu_rc, alu_val,
                            mem_we, mem_rc, mem_val, wb_we, wb_rc, wb_val);

    assign haz1_s  = load_hit(ra_s, alu_we, alu_ld, alu_rc, mem_we, mem_ld, mem_rc);
    assign haz2_s  = load_hit(r2_s, alu_we, alu_ld, alu_rc, mem_we, mem_ld, mem_rc);
    assign stall_s = haz1_s || ((is_op_s || is_st_s) && haz2_s);

    assign pc_offset_s = pc_RF + {lit_s[29:0], 2'b00};

    assign stall     = stall_s;
    assign bt        = !stall_s && ((is_beq_s && port1_s == 32'd0) ||
                                    (is_bne_s && port1_s != 32'd0));
    assign jt        = !stall_s && is_jmp_s;
    assign RF_exp    = !stall_s && is_ill_s;
    assign rd1       = port1_s;
    assign pc_offset = pc_offset_s;

    // Register file; entry 31 is never written so it stays zero.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 32; i++) regs_r[i] <= 32'd0;
        end else if (wb_we && wb_rc != 5'd31) begin
            regs_r[wb_rc] <= wb_val;
        end
    end

    // ALU-stage pipeline registers: bubble on stall, trap on illegal opcode, else operands.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            id_ALU <= NOP_INSTR;
            pc_ALU <= 32'd0;
            a_ALU  <= 32'd0;
            b_ALU  <= 32'd0;
            d_ALU  <= 32'd0;
        end else if (stall_s) begin
            id_ALU <= NOP_INSTR;
            pc_ALU <= pc_RF;
            a_ALU  <= 32'd0;
            b_ALU  <= 32'd0;
            d_ALU  <= 32'd0;
        end else if (is_ill_s) begin
            id_ALU <= XP_BNE;
            pc_ALU <= pc_RF;
            a_ALU  <= pc_RF;
            b_ALU  <= 32'd0;
            d_ALU  <= 32'd0;
        end else begin
            id_ALU <= id_RF;
            pc_ALU <= pc_RF;
            d_ALU  <= is_st_s ? port2_s : 32'd0;
            if (is_op_s) begin
                a_ALU <= port1_s;
                b_ALU <= port2_s;
            end else if (is_opc_s || is_ld_s || is_st_s) begin
                a_ALU <= port1_s;
                b_ALU <= lit_s;
            end else if (is_ldr_s) begin
                a_ALU <= pc_offset_s;
                b_ALU <= 32'd0;
            end else begin
                // BEQ/BNE/JMP carry the link value to the ALU
                a_ALU <= pc_RF;
                b_ALU <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_rf_stage.sv
// Self-checking bench for rf_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the register-fetch stage.
module tb_rf_stage;

    localparam logic [31:0] NOP = 32'h83ff_f800;
    localparam logic [31:0] XPB = 32'h77df_0000;
    localparam int C_ILL = 0, C_LD = 1, C_ST = 2, C_JMP = 3, C_BEQ = 4,
                   C_BNE = 5, C_LDR = 6, C_OP = 7, C_OPC = 8;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] id_RF, pc_RF, alu_val, mem_val, wb_val;
    logic        alu_we, alu_ld, mem_we, mem_ld, wb_we;
    logic [4:0]  alu_rc, mem_rc, wb_rc;
    logic        stall, bt, jt, RF_exp;
    logic [31:0] pc_offset, rd1, id_ALU, pc_ALU, a_ALU, b_ALU, d_ALU;

    logic [31:0] mregs [0:31];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rf_stage dut (
        .clk(clk), .n_rst(n_rst), .id_RF(id_RF), .pc_RF(pc_RF),
        .alu_we(alu_we), .alu_ld(alu_ld), .alu_rc(alu_rc), .alu_val(alu_val),
        .mem_we(mem_we), .mem_ld(mem_ld), .mem_rc(mem_rc), .mem_val(mem_val),
        .wb_we(wb_we), .wb_rc(wb_rc), .wb_val(wb_val),
        .stall(stall), .bt(bt), .jt(jt), .pc_offset(pc_offset), .rd1(rd1),
        .RF_exp(RF_exp), .id_ALU(id_ALU), .pc_ALU(pc_ALU),
        .a_ALU(a_ALU), .b_ALU(b_ALU), .d_ALU(d_ALU)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic int cls_of(input logic [5:0] op);
        int o;
        o = int'(op);
        if (o == 24) return C_LD;
        if (o == 25) return C_ST;
        if (o == 27) return C_JMP;
        if (o == 28) return C_BEQ;
        if (o == 29) return C_BNE;
        if (o == 31) return C_LDR;
        if ((o >= 32 && o <= 38) || (o >= 40 && o <= 46)) return C_OP;
        if ((o >= 48 && o <= 54) || (o >= 56 && o <= 62)) return C_OPC;
        return C_ILL;
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] r);
        if (r == 5'd31) return 32'd0;
        if (alu_we && alu_rc == r) return alu_val;
        if (mem_we && mem_rc == r) return mem_val;
        if (wb_we && wb_rc == r) return wb_val;
        return mregs[r];
    endfunction

    function automatic logic haz(input logic [4:0] r);
        return (r != 5'd31) && ((alu_we && alu_ld && alu_rc == r) ||
                                (mem_we && mem_ld && mem_rc == r));
    endfunction

    function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rc,
                                        input logic [4:0] ra, input logic [15:0] low);
        return {op, rc, ra, low};
    endfunction

    function automatic logic [4:0] rreg();
        if ($urandom_range(0, 4) == 0) return 5'd31;
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic clr();
        alu_we = 1'b0; alu_ld = 1'b0; alu_rc = 5'd0; alu_val = 32'd0;
        mem_we = 1'b0; mem_ld = 1'b0; mem_rc = 5'd0; mem_val = 32'd0;
        wb_we  = 1'b0; wb_rc  = 5'd0; wb_val = 32'd0;
        id_RF  = NOP;  pc_RF  = 32'd0;
    endtask

    // One cycle: check combinational outputs, clock, check the ALU-stage registers.
    task automatic step();
        int c;
        logic [4:0]  ra, r2;
        logic [31:0] v1, v2, litv, off, e_id, e_a, e_b, e_d;
        logic        e_st;
        #2;
        c    = cls_of(id_RF[31:26]);
        ra   = id_RF[20:16];
        r2   = (c == C_ST) ? id_RF[25:21] : id_RF[15:11];
        e_st = haz(ra) || ((c == C_OP || c == C_ST) && haz(r2));
        v1   = mread(ra);
        v2   = mread(r2);
        litv = {{16{id_RF[15]}}, id_RF[15:0]};
        off  = pc_RF + litv * 32'd4;
        check("stall", {31'd0, stall}, {31'd0, e_st});
        check("bt", {31'd0, bt}, {31'd0, !e_st && ((c == C_BEQ && v1 == 32'd0) ||
                                                    (c == C_BNE && v1 != 32'd0))});
        check("jt", {31'd0, jt}, {31'd0, !e_st && c == C_JMP});
        check("RF_exp", {31'd0, RF_exp}, {31'd0, !e_st && c == C_ILL});
        check("rd1", rd1, v1);
        check("pc_offset", pc_offset, off);
        e_id = id_RF; e_a = 32'd0; e_b = 32'd0; e_d = 32'd0;
        if (e_st) begin
            e_id = NOP;
        end else begin
            case (c)
                C_ILL:               begin e_id = XPB; e_a = pc_RF; end
                C_OP:                begin e_a = v1; e_b = v2; end
                C_OPC, C_LD:         begin e_a = v1; e_b = litv; end
                C_ST:                begin e_a = v1; e_b = litv; e_d = v2; end
                C_LDR:               e_a = off;
                default:             e_a = pc_RF;
            endcase
        end
        @(posedge clk);
        if (wb_we && wb_rc != 5'd31) mregs[wb_rc] = wb_val;
        #1;
        check("id_ALU", id_ALU, e_id);
        check("pc_ALU", pc_ALU, pc_RF);
        check("a_ALU", a_ALU, e_a);
        check("b_ALU", b_ALU, e_b);
        check("d_ALU", d_ALU, e_d);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        n_rst = 1'b0;
        clr();
        repeat (2) @(negedge clk);
        check("rst_id", id_ALU, NOP);
        check("rst_pc", pc_ALU, 32'd0);
        check("rst_a", a_ALU, 32'd0);
        check("rst_b", b_ALU, 32'd0);
        check("rst_d", d_ALU, 32'd0);
        n_rst = 1'b1;

        // bypass priority ALU > MEM > WB
        clr();
        wb_we = 1'b1;  wb_rc = 5'd1;  wb_val = 32'd5;
        mem_we = 1'b1; mem_rc = 5'd1; mem_val = 32'd7;
        alu_we = 1'b1; alu_rc = 5'd1; alu_val = 32'd9;
        id_RF = ins(6'h20, 5'd2, 5'd1, {5'd1, 11'd0}); pc_RF = 32'h40;
        step(); check("byp_alu", a_ALU, 32'd9);
        alu_we = 1'b0; step(); check("byp_mem", a_ALU, 32'd7);
        mem_we = 1'b0; step(); check("byp_wb", a_ALU, 32'd5);

        // load-use: ALU-stage load, then MEM-stage load, then WB value
        clr();
        alu_we = 1'b1; alu_ld = 1'b1; alu_rc = 5'd3; alu_val = 32'hdead_beef;
        id_RF = ins(6'h20, 5'd4, 5'd3, {5'd1, 11'd0}); pc_RF = 32'h80;
        step(); check("lu_stall1", {31'd0, stall}, 32'd1); check("lu_bub1", id_ALU, NOP);
        alu_we = 1'b0; alu_ld = 1'b0;
        mem_we = 1'b1; mem_ld = 1'b1; mem_rc = 5'd3; mem_val = 32'hdead_beef;
        step(); check("lu_stall2", {31'd0, stall}, 32'd1); check("lu_bub2", id_ALU, NOP);
        mem_we = 1'b0; mem_ld = 1'b0;
        wb_we = 1'b1; wb_rc = 5'd3; wb_val = 32'h1234_5678;
        step(); check("lu_go", {31'd0, stall}, 32'd0); check("lu_a", a_ALU, 32'h1234_5678);

        // branches
        clr(); pc_RF = 32'h100;
        id_RF = ins(6'h1C, 5'd0, 5'd31, 16'hfffe);
        step(); check("beq_bt", {31'd0, bt}, 32'd1); check("beq_off", pc_offset, 32'hf8);
        id_RF = ins(6'h1D, 5'd0, 5'd31, 16'hfffe);
        step(); check("bne_bt", {31'd0, bt}, 32'd0);
        alu_we = 1'b1; alu_ld = 1'b1; alu_rc = 5'd3; alu_val = 32'd0;
        id_RF = ins(6'h1C, 5'd0, 5'd3, 16'hfffe);
        step(); check("br_stall_bt", {31'd0, bt}, 32'd0);

        // JMP through R4
        clr(); wb_we = 1'b1; wb_rc = 5'd4; wb_val = 32'h8000_0040;
        step();
        clr(); id_RF = ins(6'h1B, 5'd0, 5'd4, 16'd0); pc_RF = 32'h200;
        step(); check("jmp_jt", {31'd0, jt}, 32'd1);
        check("jmp_rd1", rd1, 32'h8000_0040); check("jmp_a", a_ALU, 32'h200);

        // illegal opcode, then ST
        clr(); id_RF = ins(6'h00, 5'd1, 5'd2, 16'd0); pc_RF = 32'h300;
        step(); check("ill_exp", {31'd0, RF_exp}, 32'd1);
        check("ill_id", id_ALU, XPB); check("ill_a", a_ALU, 32'h300);
        clr(); wb_we = 1'b1; wb_rc = 5'd5; wb_val = 32'hcafe_0005;
        step();
        clr(); id_RF = ins(6'h19, 5'd5, 5'd6, 16'h8010); pc_RF = 32'h304;
        step(); check("st_d", d_ALU, 32'hcafe_0005); check("st_b", b_ALU, 32'hffff_8010);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            alu_we = 1'($urandom_range(0, 1)); alu_ld = ($urandom_range(0, 3) == 0);
            alu_rc = rreg(); alu_val = $urandom;
            mem_we = 1'($urandom_range(0, 1)); mem_ld = ($urandom_range(0, 3) == 0);
            mem_rc = rreg(); mem_val = $urandom;
            wb_we = ($urandom_range(0, 3) != 0); wb_rc = rreg(); wb_val = $urandom;
            if ($urandom_range(0, 7) == 0)
                id_RF[31:26] = 6'($urandom);
            else
                id_RF[31:26] = 6'($urandom_range(24, 63));
            id_RF[25:0] = {rreg(), rreg(), rreg(), 11'($urandom)};
            pc_RF = $urandom;
            step();
        end

        // reset asserted while stalled
        clr();
        alu_we = 1'b1; alu_ld = 1'b1; alu_rc = 5'd3;
        id_RF = ins(6'h20, 5'd4, 5'd3, {5'd1, 11'd0}); pc_RF = 32'h500;
        #2; check("mrst_stall", {31'd0, stall}, 32'd1);
        n_rst = 1'b0;
        #1;
        check("mrst_id", id_ALU, NOP); check("mrst_pc", pc_ALU, 32'd0);
        check("mrst_a", a_ALU, 32'd0); check("mrst_b", b_ALU, 32'd0);
        check("mrst_d", d_ALU, 32'd0);
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        @(negedge clk);
        n_rst = 1'b1;
        clr(); id_RF = ins(6'h20, 5'd2, 5'd1, {5'd1, 11'd0}); pc_RF = 32'h600;
        step(); check("mrst_r1", a_ALU, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
